// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the 64-bit ALU multiply/divide datapath.
package alu_pkg;
    localparam int ALU_W     = 64;
    localparam int C1_LOAD_Q = 1;
    localparam int C4_SHIFT  = 4;
    localparam int C6_OUT_Q  = 6;
endpackage

// File: rtl/reg_q_shift_reg_cell.sv
// shift_reg_cell: one Q bit with sync active-low reset and load > shift > hold priority.
module shift_reg_cell (
    input  logic clk,
    input  logic rst_b,
    input  logic i_load,
    input  logic i_shift,
    input  logic i_d,
    input  logic i_s,
    output logic o_q
);
    logic r_q;
    always_ff @(posedge clk)
        if (!rst_b) r_q <= 1'b0;
        else if (i_load) r_q <= i_d;
        else if (i_shift) r_q <= i_s;
    assign o_q = r_q;
endmodule

// File: rtl/reg_q.sv
// reg_q: Q register (multiplier/quotient) with A->Q right shift and bus driver.
// Define REG_Q_TRISTATE_EN to float outbus when c6 is low instead of driving zeros.
module reg_q
    import alu_pkg::*;
#(
    parameter int w = ALU_W
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         c1,
    input  logic         c4,
    input  logic         c6,
    input  logic [w-1:0] inbus,
    input  logic         A_lsb,
    output logic         Q_lsb,
    output logic [w-1:0] outbus
);
    logic [w-1:0] w_q;
    logic [w-1:0] w_ser;
    // Each bit's serial input is its left neighbour; the top bit takes A's LSB.
    assign w_ser = {A_lsb, w_q[w-1:1]};
    for (genvar g = 0; g < w; g++) begin : g_cell
        shift_reg_cell u_cell (
            .clk    (clk),
            .rst_b  (rst_b),
            .i_load (c1),
            .i_shift(c4),
            .i_d    (inbus[g]),
            .i_s    (w_ser[g]),
            .o_q    (w_q[g])
        );
    end
    assign Q_lsb = w_q[0];
`ifdef REG_Q_TRISTATE_EN
    assign outbus = c6 ? w_q : 'z;
`else
    assign outbus = c6 ? w_q : '0;
`endif
endmodule

// File: tb/tb_reg_q.sv
// tb_reg_q: directed plus randomized checks of reg_q (w=16) against an arithmetic model.
module tb_reg_q;
    localparam int W = 16;
    logic         clk = 1'b0;
    logic         rst_b, c1, c4, c6, A_lsb;
    logic [W-1:0] inbus;
    logic         Q_lsb;
    logic [W-1:0] outbus;
    logic [W-1:0] m_q;
    int total = 0;
    int bad   = 0;
    logic [W-1:0] pat;

    reg_q #(.w(W)) dut (
        .clk(clk), .rst_b(rst_b), .c1(c1), .c4(c4), .c6(c6),
        .inbus(inbus), .A_lsb(A_lsb), .Q_lsb(Q_lsb), .outbus(outbus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_next(logic [W-1:0] q, logic rb, logic l, logic s,
                                                logic [W-1:0] d, logic a);
        int unsigned v;
        if (!rb) return '0;
        if (l) return d;
        if (s) begin
            v = int'(q) / 2 + int'(a) * (1 << (W - 1));
            return v[W-1:0];
        end
        return q;
    endfunction

    function automatic logic [W-1:0] bus_exp(logic oe, logic [W-1:0] q);
`ifdef REG_Q_TRISTATE_EN
        return oe ? q : 'z;
`else
        return oe ? q : '0;
`endif
    endfunction

    task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        m_q = model_next(m_q, rst_b, c1, c4, inbus, A_lsb);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(string tag);
        chk({tag, "_bus"}, outbus, bus_exp(c6, m_q));
        chk({tag, "_lsb"}, {15'b0, Q_lsb}, {15'b0, m_q[0]});
    endtask

    initial begin
        m_q = 'x;
        rst_b = 1'b0; c1 = 1'b1; c4 = 1'b0; c6 = 1'b1; inbus = 16'hBEEF; A_lsb = 1'b0;
        tick();
        chk("reset_bus", outbus, 16'h0000);
        chk("reset_lsb", {15'b0, Q_lsb}, 16'h0000);

        rst_b = 1'b1; c1 = 1'b1; c6 = 1'b0; inbus = 16'h8001;
        tick();
        c1 = 1'b0; #1;
        chk("load_bus_off", outbus, bus_exp(1'b0, 16'h8001));
        c6 = 1'b1; #1;
        chk("load_bus_on", outbus, 16'h8001);
        chk("load_lsb", {15'b0, Q_lsb}, 16'h0001);

        c4 = 1'b1; A_lsb = 1'b1;
        tick();
        chk("shift1", outbus, 16'hC000);
        chk("shift1_lsb", {15'b0, Q_lsb}, 16'h0000);
        A_lsb = 1'b0;
        tick();
        chk("shift2", outbus, 16'h6000);

        c4 = 1'b0; c1 = 1'b1; inbus = 16'hFFFF;
        tick();
        c4 = 1'b1; inbus = 16'h1234;
        tick();
        chk("prio", outbus, 16'h1234);
        c1 = 1'b0; c4 = 1'b0; inbus = 16'hDEAD;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold", outbus, 16'h1234);
        end

        c1 = 1'b1; inbus = 16'hA5A5;
        tick();
        c1 = 1'b0; c4 = 1'b1;
        pat = 16'b0100_1111_0000_1101;
        for (int i = 0; i < W; i++) begin
            A_lsb = pat[i];
            tick();
        end
        chk("fullshift", outbus, 16'h4F0D);
        chk("fullshift_model", outbus, m_q);

        for (int i = 0; i < 50; i++) begin
            rst_b = !(i == 25 || $urandom_range(15) == 0);
            c1    = 1'($urandom);
            c4    = 1'($urandom);
            c6    = 1'($urandom);
            inbus = 16'($urandom);
            A_lsb = 1'($urandom);
            #1;
            chk_state("rnd_pre");
            tick();
            chk_state("rnd_post");
            if (i == 25) chk("rnd_midreset", {15'b0, Q_lsb}, 16'h0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
